// File: rtl/simon_sequence_player.sv
// Plays a Simon Says colour sequence on four one-hot LEDs, one phase per divider tick.
// Colours come from a seeded 16-bit LFSR, so reloading the same seed replays the same prefix.
module simon_sequence_player #(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  seq_len,
  input  logic [15:0] seed,
  output logic [3:0]  led,
  output logic        busy,
  output logic        done,
  output logic [4:0]  step_idx
);

  localparam logic [4:0] MaxLen = 5'(MAX_LEN);

  typedef enum logic [2:0] {StIdle, StArm, StOn, StGap, StDone} state_e;

  state_e      state_q;
  logic [15:0] lfsr_q;
  logic [4:0]  len_q;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] c);
    return 4'b0001 << c;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      lfsr_q   <= DEFAULT_SEED;
      len_q    <= '0;
      led      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      step_idx <= '0;
    end else begin
      done <= 1'b0;
      // Abort only cancels active playback; in IDLE a simultaneous start still wins.
      if (abort && state_q != StIdle) begin
        state_q <= StIdle;
        led     <= '0;
        busy    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && seq_len != 5'd0) begin
              len_q    <= (seq_len > MaxLen) ? MaxLen : seq_len;
              lfsr_q   <= (seed == 16'h0000) ? DEFAULT_SEED : seed;
              step_idx <= '0;
              busy     <= 1'b1;
              state_q  <= StArm;
            end
          end
          StArm: begin
            if (tick) begin
              led     <= onehot(lfsr_q[1:0]);
              state_q <= StOn;
            end
          end
          StOn: begin
            if (tick) begin
              led      <= '0;
              lfsr_q   <= lfsr_next(lfsr_q);
              step_idx <= step_idx + 5'd1;
              state_q  <= StGap;
            end
          end
          StGap: begin
            if (tick) begin
              if (step_idx == len_q) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                led     <= '0;
                state_q <= StDone;
              end else begin
                led     <= onehot(lfsr_q[1:0]);
                state_q <= StOn;
              end
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
            led     <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
// Scoreboard bench: stimulus pushes expected ON colours/durations and done events,
// a negedge monitor pops and compares whenever the DUT lights an LED or pulses done.
module tb_simon_sequence_player;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick, start, abort;
  logic [4:0]  seq_len;
  logic [15:0] seed;
  logic [3:0]  led;
  logic        busy, done;
  logic [4:0]  step_idx;

  simon_sequence_player dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .abort    (abort),
    .seq_len  (seq_len),
    .seed     (seed),
    .led      (led),
    .busy     (busy),
    .done     (done),
    .step_idx (step_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [4:0]  val;   // led colour, or final step_idx for a done event
    int          dur;   // expected ON length in cycles, 0 = not checked
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: spec-level LFSR and colour mapping.
  function automatic logic [15:0] ref_step(input logic [15:0] l);
    logic fb;
    fb = l[15] ^ l[13] ^ l[12] ^ l[10];
    return (l << 1) | {15'd0, fb};
  endfunction

  function automatic logic [3:0] ref_colour(input logic [15:0] l);
    case (l % 4)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  // Monitor
  logic [3:0] prev_led = '0;
  logic [3:0] cur_led  = '0;
  int         run_len  = 0;

  always @(negedge clk) begin
    exp_t e;
    if (led != 4'd0) begin
      if (prev_led == 4'd0) begin
        cur_led = led;
        run_len = 0;
      end
      run_len++;
    end else if (prev_led != 4'd0) begin
      if (q.size() == 0) begin
        check("unexpected_led_phase", {28'd0, cur_led}, 32'd0);
      end else begin
        e = q.pop_front();
        check("phase_kind", {31'd0, e.is_done}, 32'd0);
        check("led_colour", {28'd0, cur_led}, {27'd0, e.val});
        if (e.dur != 0) check("on_duration", run_len, e.dur);
      end
    end
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("done_kind", {31'd0, e.is_done}, 32'd1);
        check("done_step_idx", {27'd0, step_idx}, {27'd0, e.val});
        check("done_busy_low", {31'd0, busy}, 32'd0);
      end
    end
    prev_led = (led === 4'bxxxx) ? 4'd0 : led;
  end

  // One clock with the given pulse inputs; returns 1 time unit after the sampling edge.
  task automatic cyc(input logic tk, input logic st, input logic ab);
    tick  = tk;
    start = st;
    abort = ab;
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic run_round(input logic [15:0] sd, input logic [4:0] sl, input int per,
                           input int abort_on, input bit stray, input bit coinc);
    int          len, nt;
    logic [15:0] l;
    exp_t        e;
    len = (sl > 5'd16) ? 16 : int'(sl);
    l   = (sd == 16'd0) ? 16'hACE1 : sd;
    for (int i = 0; i < len; i++) begin
      if (abort_on == 0 || i < abort_on) begin
        e.is_done = 1'b0;
        e.val     = {1'b0, ref_colour(l)};
        e.dur     = (abort_on != 0 && i == abort_on - 1) ? 0 : per;
        q.push_back(e);
      end
      l = ref_step(l);
    end
    if (abort_on == 0) begin
      e.is_done = 1'b1;
      e.val     = 5'(len);
      e.dur     = 0;
      q.push_back(e);
    end
    seed    = sd;
    seq_len = sl;
    cyc(coinc, 1'b1, 1'b0);
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("step_idx_cleared", {27'd0, step_idx}, 32'd0);
    nt = (abort_on != 0) ? 2 * abort_on - 1 : 1 + 2 * len;
    for (int t = 0; t < nt; t++) begin
      for (int k = 0; k < per - 1; k++) begin
        if (stray && t == 2 && k == 0) begin
          seed    = ~sd;
          seq_len = 5'd1;
          cyc(1'b0, 1'b1, 1'b0);
        end else begin
          cyc(1'b0, 1'b0, 1'b0);
        end
      end
      if (coinc && t == 0) check("coinc_still_dark", {28'd0, led}, 32'd0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    if (abort_on != 0) begin
      cyc(1'b0, 1'b0, 1'b1);
      check("abort_led", {28'd0, led}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_step_idx", {27'd0, step_idx}, 32'(abort_on - 1));
      for (int k = 0; k < 2 * per + 2; k++) cyc(1'b1, 1'b0, 1'b0);
    end else begin
      check("done_on_time", {31'd0, done}, 32'd1);
      cyc(1'b0, 1'b0, 1'b0);
      check("done_single_cycle", {31'd0, done}, 32'd0);
      check("step_idx_hold", {27'd0, step_idx}, 32'(len));
    end
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b0; tick = 1'b0; start = 1'b0; abort = 1'b0;
    seq_len = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check("rst_led", {28'd0, led}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_step_idx", {27'd0, step_idx}, 32'd0);

    seq_len = 5'd0;
    cyc(1'b0, 1'b1, 1'b0);
    check("len0_no_busy", {31'd0, busy}, 32'd0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);

    run_round(16'h0001, 5'd4, 4, 0, 1'b0, 1'b0);
    run_round(16'hBEEF, 5'd3, 3, 0, 1'b0, 1'b0);
    run_round(16'hBEEF, 5'd4, 2, 0, 1'b0, 1'b0);
    run_round(16'h0000, 5'd31, 2, 0, 1'b0, 1'b0);
    run_round(16'h1234, 5'd5, 3, 2, 1'b0, 1'b0);
    run_round(16'h5A5A, 5'd3, 3, 0, 1'b1, 1'b0);

    // Reset during a GAP
    e.is_done = 1'b0; e.val = {1'b0, ref_colour(16'h0001)}; e.dur = 3;
    q.push_back(e);
    seed = 16'h0001; seq_len = 5'd4;
    cyc(1'b0, 1'b1, 1'b0);
    repeat (2) begin
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    check("midrst_led", {28'd0, led}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_step_idx", {27'd0, step_idx}, 32'd0);
    repeat (4) cyc(1'b1, 1'b0, 1'b0);

    run_round(16'h0001, 5'd2, 3, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_round(16'($urandom), 5'($urandom_range(1, 20)), $urandom_range(1, 4), 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    run_round(16'($urandom), 5'd6, $urandom_range(2, 4), $urandom_range(1, 6), 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
